// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings and sizes for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W           = 4;
    localparam int unsigned DEFAULT_NIBBLES = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/fa4_mbit.sv
// Combinational 4-bit full adder: one slice of the serial wide adder.
module fa4_mbit
    import nibble_serial_adder_pkg::*;
(
    output logic [NIB_W-1:0] s,
    output logic             co,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci
);

    logic [NIB_W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
    end

    assign s  = sum[NIB_W-1:0];
    assign co = sum[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses a single 4-bit adder, one slice per clock, with a
// registered carry between slices. Results appear only when complete.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = DEFAULT_NIBBLES,
    localparam int unsigned W = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
);

    localparam int unsigned IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_e        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;
    logic          carry;
    logic [IW-1:0] idx;

    logic [NIB_W-1:0] fa_a;
    logic [NIB_W-1:0] fa_b;
    logic [NIB_W-1:0] fa_s;
    logic             fa_co;

    always_comb begin
        fa_a = a_reg[NIB_W*idx +: NIB_W];
        fa_b = b_reg[NIB_W*idx +: NIB_W];
    end

    fa4_mbit u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (fa_a),
        .b  (fa_b),
        .ci (carry)
    );

    // Work sum with the current slice merged in, so the final copy to s is complete.
    always_comb begin
        work_next = work;
        work_next[NIB_W*idx +: NIB_W] = fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= ci;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    work  <= work_next;
                    carry <= fa_co;
                    if (idx == LAST_IDX) begin
                        s     <= work_next;
                        co    <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against a+b+ci arithmetic.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;

    int total;
    int bad;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    // Issues one start pulse and watches until done (bounded). Scrambles the
    // operand inputs right after acceptance to show they are not re-sampled.
    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oci,
                         output int lat, output int busy_cnt, output bit held_ok);
        logic [15:0] s0;
        logic        co0;
        int          cnt;
        s0 = s;
        co0 = co;
        held_ok = 1'b1;
        busy_cnt = 0;
        lat = 0;
        cnt = 0;
        @(negedge clk);
        a = oa;
        b = ob;
        ci = oci;
        start = 1'b1;
        while (lat == 0 && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                ci = 1'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) lat = cnt;
            else if (s !== s0 || co !== co0) held_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        a = 16'hA5A5;
        b = 16'h5A5A;
        ci = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, co, s} !== 19'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b co=%b s=%h, want all zero",
                     busy, done, co, s);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vc [6];
        logic [16:0] exp;
        int          lat;
        int          bc;
        bit          held;
        va = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h0F0F};
        vb = '{16'h4321, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'hF0F0};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            exp = ref_sum(va[i], vb[i], vc[i]);
            do_op(va[i], vb[i], vc[i], lat, bc, held);
            total++;
            if (lat != 5) begin
                bad++;
                $display("FAIL latency[%0d]: done seen after %0d cycles, want 5", i, lat);
            end
            total++;
            if (bc != 4) begin
                bad++;
                $display("FAIL busy_len[%0d]: busy for %0d cycles, want 4", i, bc);
            end
            total++;
            if ({co, s} !== exp) begin
                bad++;
                $display("FAIL sum[%0d]: {co,s}=%h, want %h", i, {co, s}, exp);
            end
            total++;
            if (!held) begin
                bad++;
                $display("FAIL hold[%0d]: s/co changed before done, want held", i);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || {co, s} !== exp) begin
                bad++;
                $display("FAIL pulse[%0d]: done=%b {co,s}=%h, want 0 %h", i, done, {co, s}, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        int          dones;
        logic [16:0] got;
        dones = 0;
        got = '0;
        @(negedge clk);
        a = 16'h1234;
        b = 16'h1111;
        ci = 1'b0;
        start = 1'b1;
        for (int cnt = 1; cnt <= 14; cnt++) begin
            @(negedge clk);
            if (cnt == 1) start = 1'b0;
            if (cnt == 2) begin
                a = 16'hAAAA;
                b = 16'h5555;
                ci = 1'b1;
                start = 1'b1;
            end
            if (cnt == 3) start = 1'b0;
            if (done) begin
                dones++;
                got = {co, s};
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL ignore_start_dones: %0d done pulses, want 1", dones);
        end
        total++;
        if (got !== 17'h02345) begin
            bad++;
            $display("FAIL ignore_start_sum: {co,s}=%h, want 02345", got);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        int lat;
        int bc;
        bit held;
        dones = 0;
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0001;
        ci = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, co, s} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b co=%b s=%h, want all zero",
                     busy, done, co, s);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (done) dones++;
        end
        total++;
        if (dones != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done: dones=%0d busy=%b, want 0 0", dones, busy);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, lat, bc, held);
        total++;
        if (lat != 5 || {co, s} !== 17'h00100) begin
            bad++;
            $display("FAIL after_reset_op: lat=%0d {co,s}=%h, want 5 00100", lat, {co, s});
        end
    endtask

    task automatic test_back_to_back;
        logic [16:0] exp;
        int          since;
        bit          got;
        @(negedge clk);
        a = 16'($urandom);
        b = 16'($urandom);
        ci = 1'($urandom);
        exp = ref_sum(a, b, ci);
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            since = 0;
            got = 1'b0;
            while (!got && since < 20) begin
                @(negedge clk);
                since++;
                if (done) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL b2b_timeout[%0d]: no done in %0d cycles, want one", i, since);
            end
            total++;
            if ({co, s} !== exp) begin
                bad++;
                $display("FAIL b2b_sum[%0d]: {co,s}=%h, want %h", i, {co, s}, exp);
            end
            if (i > 0) begin
                total++;
                if (since != 6) begin
                    bad++;
                    $display("FAIL b2b_period[%0d]: done spacing %0d, want 6", i, since);
                end
            end
            a = 16'($urandom);
            b = 16'($urandom);
            ci = 1'($urandom);
            exp = ref_sum(a, b, ci);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
